// File: rtl/ltc2387_pkg.sv
// Shared types and helpers for the LTC2387 multi-channel receiver.
// Provides the frame state encoding, the per-frame burst length and the
// minimum legal frame length.
package ltc2387_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        BURST = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // One spare frame cycle after the last capture, in which adc_data is loaded.
    localparam int unsigned PMIN_MARGIN = 1;

    // Number of data-clock cycles needed to move one sample.
    function automatic int unsigned ncyc(input logic two_lane, input int unsigned bits);
        return two_lane ? (bits / 2) : bits;
    endfunction

    // Shortest frame that still fits conversion, burst, capture latency and load.
    function automatic int unsigned pmin(input logic two_lane, input int unsigned bits,
                                         input int unsigned burst_start,
                                         input int unsigned latency);
        return burst_start + ncyc(two_lane, bits) + latency + PMIN_MARGIN;
    endfunction

endpackage

// File: rtl/ltc2387_deser.sv
// Per-channel deserialiser: shifts lane bits in while cap_en is high, loads
// the finished word into data on the last capture, and flags any returned
// DCO level that does not match the expected capture parity.
// Ports:
//   clk, resetn   ADC clock, synchronous active-low reset
//   cap_en        capture qualifier (delayed clkout_en)
//   cap_par       expected DCO level for this capture (capture index bit 0)
//   cap_last      current capture is the final one of the burst
//   two_lane      latched lane mode for this frame
//   clr_err       clears sync_err unless a mismatch happens in the same cycle
//   din_a, din_b  lane A / lane B serial bits
//   dco           returned data clock, sampled as data
//   data          last complete sample, held between loads
//   sync_err      sticky DCO mismatch flag
module ltc2387_deser #(
    parameter int unsigned BITS = 18
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cap_en,
    input  logic            cap_par,
    input  logic            cap_last,
    input  logic            two_lane,
    input  logic            clr_err,
    input  logic            din_a,
    input  logic            din_b,
    input  logic            dco,
    output logic [BITS-1:0] data,
    output logic            sync_err
);

    logic [BITS-1:0] sh;
    logic [BITS-1:0] sh_nxt_c;
    logic            mism_c;

    // Lane A carries the more significant bit of each pair.
    always_comb begin
        sh_nxt_c = two_lane ? {sh[BITS-3:0], din_a, din_b} : {sh[BITS-2:0], din_a};
        mism_c   = cap_en && (dco != cap_par);
    end

    // Shift register, output word and sticky error flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh       <= '0;
            data     <= '0;
            sync_err <= 1'b0;
        end else begin
            if (cap_en) begin
                sh <= sh_nxt_c;
            end
            if (cap_en && cap_last) begin
                data <= sh_nxt_c;
            end
            // A mismatch in the clearing cycle keeps the flag set.
            if (mism_c) begin
                sync_err <= 1'b1;
            end else if (clr_err) begin
                sync_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ltc2387_rx_multi.sv
// Receiver for N_CH LTC2387-family ADCs sharing cnv and the forwarded data
// clock. Runs a frame counter that issues cnv and gates the clock burst,
// delays the gate by LATENCY to qualify captures, and deserialises every
// channel in lock-step.
// Ports:
//   clk, resetn        ADC clock, synchronous active-low reset
//   enable             run frames while high (a running frame always completes)
//   two_lane, period   lane mode and frame length, sampled on the frame-start edge
//   clr_err            clears sync_err
//   din_a, din_b, dco  per-channel serial lanes and returned DCO
//   cnv                one-cycle conversion pulse at frame cycle 0
//   clkout_en          data-clock gate, frame cycles BURST_START..BURST_START+NCYC-1
//   adc_data           channel c at [c*BITS +: BITS], held between strobes
//   adc_valid          one-cycle strobe in the cycle adc_data updates
//   sync_err           sticky per-channel DCO mismatch flags
//   cfg_err            current frame's period was below the minimum and was clamped
module ltc2387_rx_multi
    import ltc2387_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned BITS        = 18,
    parameter int unsigned BURST_START = 2,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned PW          = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 two_lane,
    input  logic [PW-1:0]        period,
    input  logic                 clr_err,
    input  logic [N_CH-1:0]      din_a,
    input  logic [N_CH-1:0]      din_b,
    input  logic [N_CH-1:0]      dco,
    output logic                 cnv,
    output logic                 clkout_en,
    output logic [N_CH*BITS-1:0] adc_data,
    output logic                 adc_valid,
    output logic [N_CH-1:0]      sync_err,
    output logic                 cfg_err
);

    localparam int unsigned KW = $clog2(BITS + 1);

    state_t             state;
    state_t             nxt_state;
    logic [PW-1:0]      cnt;
    logic [PW-1:0]      nxt_cnt;
    logic [PW-1:0]      last_q;
    logic               lane2_q;
    logic               start_c;
    logic [PW-1:0]      ncyc_c;
    logic [PW-1:0]      pmin_c;
    logic [PW-1:0]      per_eff_c;
    logic               short_c;
    logic [LATENCY-1:0] cap_sr;
    logic               cap_en;
    logic [KW-1:0]      cap_idx;
    logic               cap_last_c;

    // Frame phase for a given counter value and burst length.
    function automatic state_t phase_of(input logic [PW-1:0] c, input logic [PW-1:0] n);
        if (c < PW'(BURST_START)) begin
            return CONV;
        end else if (c < PW'(BURST_START) + n) begin
            return BURST;
        end
        return WAIT;
    endfunction

    // Period clamp for the frame about to start.
    always_comb begin
        pmin_c    = PW'(pmin(two_lane, BITS, BURST_START, LATENCY));
        short_c   = (period < pmin_c);
        per_eff_c = short_c ? pmin_c : period;
    end

    // Next frame position; a new frame uses the live config, a running one the latched config.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        start_c   = 1'b0;
        ncyc_c    = PW'(ncyc(lane2_q, BITS));
        if (state == IDLE) begin
            start_c = enable;
        end else if (cnt == last_q) begin
            if (enable) begin
                start_c = 1'b1;
            end else begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        end else begin
            nxt_cnt   = cnt + 1'b1;
            nxt_state = phase_of(nxt_cnt, ncyc_c);
        end
        if (start_c) begin
            ncyc_c    = PW'(ncyc(two_lane, BITS));
            nxt_cnt   = '0;
            nxt_state = phase_of(PW'(0), ncyc_c);
        end
    end

    assign cap_en     = cap_sr[LATENCY-1];
    assign cap_last_c = (cap_idx == KW'(ncyc(lane2_q, BITS) - 1));

    // Frame FSM, registered pin outputs, config latch and capture tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            last_q    <= '0;
            lane2_q   <= 1'b0;
            cnv       <= 1'b0;
            clkout_en <= 1'b0;
            cfg_err   <= 1'b0;
            cap_sr    <= '0;
            cap_idx   <= '0;
            adc_valid <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            cnv       <= start_c;
            clkout_en <= (nxt_state == BURST);
            if (start_c) begin
                lane2_q <= two_lane;
                last_q  <= per_eff_c - 1'b1;
                cfg_err <= short_c;
            end
            // Delay line from the clock gate to the capture qualifier.
            cap_sr    <= LATENCY'({cap_sr, clkout_en});
            cap_idx   <= cap_en ? cap_idx + 1'b1 : '0;
            adc_valid <= cap_en && cap_last_c;
        end
    end

    for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
        ltc2387_deser #(
            .BITS(BITS)
        ) u_deser (
            .clk      (clk),
            .resetn   (resetn),
            .cap_en   (cap_en),
            .cap_par  (cap_idx[0]),
            .cap_last (cap_last_c),
            .two_lane (lane2_q),
            .clr_err  (clr_err),
            .din_a    (din_a[c]),
            .din_b    (din_b[c]),
            .dco      (dco[c]),
            .data     (adc_data[c*BITS +: BITS]),
            .sync_err (sync_err[c])
        );
    end

endmodule

// File: tb/tb_ltc2387_rx_multi.sv
// Self-checking bench for ltc2387_rx_multi. Each frame is described by its
// configuration and sample; the expected pin timeline follows directly from
// the frame rules (cnv at 0, gate for NCYC cycles from BURST_START, strobe at
// BURST_START+NCYC+LATENCY, clamped length) and the bench plays the ADC.
module tb_ltc2387_rx_multi;

    localparam int N_CH = 2;
    localparam int BITS = 18;
    localparam int BS   = 2;
    localparam int LAT  = 1;
    localparam int PW   = 8;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 enable;
    logic                 two_lane;
    logic [PW-1:0]        period;
    logic                 clr_err;
    logic [N_CH-1:0]      din_a;
    logic [N_CH-1:0]      din_b;
    logic [N_CH-1:0]      dco;
    logic                 cnv;
    logic                 clkout_en;
    logic [N_CH*BITS-1:0] adc_data;
    logic                 adc_valid;
    logic [N_CH-1:0]      sync_err;
    logic                 cfg_err;

    int                   n_chk = 0;
    int                   n_bad = 0;
    logic [N_CH*BITS-1:0] last_smp;
    logic [N_CH-1:0]      exp_sync;

    ltc2387_rx_multi #(
        .N_CH(N_CH), .BITS(BITS), .BURST_START(BS), .LATENCY(LAT), .PW(PW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .two_lane  (two_lane),
        .period    (period),
        .clr_err   (clr_err),
        .din_a     (din_a),
        .din_b     (din_b),
        .dco       (dco),
        .cnv       (cnv),
        .clkout_en (clkout_en),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .sync_err  (sync_err),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N_CH*BITS-1:0] rand_smp();
        logic [N_CH*BITS-1:0] r;
        for (int c = 0; c < N_CH; c++) r[c*BITS +: BITS] = BITS'($urandom);
        return r;
    endfunction

    // Plays one frame. Must be entered so that the next negedge lies in frame cycle 0.
    // The next frame's inputs are driven at chg_at and again in the last cycle.
    task automatic do_frame(input logic tl, input int per, input logic [N_CH*BITS-1:0] smp,
                            input logic [N_CH-1:0] dco_bad, input logic nx_tl, input int nx_per,
                            input logic nx_en, input int chg_at, input int clr_at);
        int n, pm, len, vc, k;
        logic cfg_exp;
        logic [N_CH-1:0] mism;
        n       = tl ? BITS / 2 : BITS;
        pm      = BS + n + LAT + 1;
        len     = (per < pm) ? pm : per;
        cfg_exp = (per < pm);
        vc      = BS + n + LAT;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            chk("cnv", 64'(cnv), 64'(j == 0));
            chk("clkout_en", 64'(clkout_en), 64'(j >= BS && j < BS + n));
            chk("adc_valid", 64'(adc_valid), 64'(j == vc));
            chk("cfg_err", 64'(cfg_err), 64'(cfg_exp));
            chk("adc_data", 64'(adc_data), 64'((j >= vc) ? smp : last_smp));
            chk("sync_err", 64'(sync_err), 64'(exp_sync));
            k       = j - BS - LAT;
            din_a   = N_CH'($urandom);
            din_b   = N_CH'($urandom);
            dco     = N_CH'($urandom);
            clr_err = (j == clr_at);
            mism    = '0;
            if (k >= 0 && k < n) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (tl) begin
                        din_a[c] = smp[c*BITS + BITS - 1 - 2*k];
                        din_b[c] = smp[c*BITS + BITS - 2 - 2*k];
                    end else begin
                        din_a[c] = smp[c*BITS + BITS - 1 - k];
                    end
                    dco[c]  = dco_bad[c] ? 1'b0 : k[0];
                    mism[c] = (dco[c] != k[0]);
                end
            end
            exp_sync = mism | (clr_err ? '0 : exp_sync);
            if (j == chg_at || j == len - 1) begin
                two_lane = nx_tl;
                period   = PW'(nx_per);
                enable   = nx_en;
            end
        end
        last_smp = smp;
    endtask

    // Idle cycles after enable dropped; the last one re-enables with the given config.
    task automatic idle_cycles(input int m, input logic nx_tl, input int nx_per);
        for (int i = 0; i < m; i++) begin
            @(negedge clk);
            chk("idle_cnv", 64'(cnv), 64'(0));
            chk("idle_clkout_en", 64'(clkout_en), 64'(0));
            chk("idle_adc_valid", 64'(adc_valid), 64'(0));
            chk("idle_adc_data", 64'(adc_data), 64'(last_smp));
            clr_err = 1'b0;
            din_a   = N_CH'($urandom);
            dco     = N_CH'($urandom);
            if (i == m - 1) begin
                enable   = 1'b1;
                two_lane = nx_tl;
                period   = PW'(nx_per);
            end
        end
    endtask

    // Runs into a frame and pulses reset during frame cycle 6.
    task automatic reset_mid(input logic nx_tl, input int nx_per);
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            clr_err = 1'b0;
            din_a   = N_CH'($urandom);
            din_b   = N_CH'($urandom);
            dco     = N_CH'($urandom);
            if (j == 6) resetn = 1'b0;
        end
        @(negedge clk);
        chk("rst_cnv", 64'(cnv), 64'(0));
        chk("rst_clkout_en", 64'(clkout_en), 64'(0));
        chk("rst_adc_valid", 64'(adc_valid), 64'(0));
        chk("rst_adc_data", 64'(adc_data), 64'(0));
        chk("rst_sync_err", 64'(sync_err), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        resetn   = 1'b1;
        enable   = 1'b1;
        two_lane = nx_tl;
        period   = PW'(nx_per);
        last_smp = '0;
        exp_sync = '0;
    endtask

    initial begin
        logic [N_CH*BITS-1:0] smp1;
        logic cur_tl, nx_tl;
        int   cur_per, nx_per;
        resetn   = 1'b0;
        enable   = 1'b0;
        two_lane = 1'b0;
        period   = '0;
        clr_err  = 1'b0;
        din_a    = '0;
        din_b    = '0;
        dco      = '0;
        last_smp = '0;
        exp_sync = '0;
        repeat (2) @(negedge clk);
        chk("reset_cnv", 64'(cnv), 64'(0));
        chk("reset_clkout_en", 64'(clkout_en), 64'(0));
        chk("reset_adc_valid", 64'(adc_valid), 64'(0));
        chk("reset_adc_data", 64'(adc_data), 64'(0));
        chk("reset_sync_err", 64'(sync_err), 64'(0));
        chk("reset_cfg_err", 64'(cfg_err), 64'(0));
        resetn   = 1'b1;
        enable   = 1'b1;
        two_lane = 1'b1;
        period   = PW'(16);

        // Two-lane reference pattern, two frames back to back.
        smp1 = {18'h3CC3F, 18'h330FC};
        do_frame(1'b1, 16, smp1, '0, 1'b1, 16, 1'b1, -1, -1);
        do_frame(1'b1, 16, smp1, '0, 1'b0, 24, 1'b1, -1, -1);

        // One-lane.
        smp1 = {BITS'($urandom), 18'h2AAAA};
        do_frame(1'b0, 24, smp1, '0, 1'b1, 5, 1'b1, -1, -1);

        // Period clamp to 13.
        do_frame(1'b1, 5, rand_smp(), '0, 1'b1, 16, 1'b1, -1, -1);

        // DCO fault on channel 1: sticky, clear loses to a same-cycle mismatch, then clears once fixed.
        do_frame(1'b1, 16, rand_smp(), 2'b10, 1'b1, 16, 1'b1, -1, -1);
        do_frame(1'b1, 16, rand_smp(), 2'b10, 1'b1, 16, 1'b1, -1, BS + LAT + 1);
        do_frame(1'b1, 16, rand_smp(), '0, 1'b1, 16, 1'b1, -1, 1);
        do_frame(1'b1, 16, rand_smp(), '0, 1'b1, 16, 1'b1, -1, -1);

        // Mode change mid-frame, then enable dropped mid-frame.
        do_frame(1'b1, 16, rand_smp(), '0, 1'b0, 24, 1'b1, 5, -1);
        do_frame(1'b0, 24, rand_smp(), '0, 1'b0, 24, 1'b0, 3, -1);
        idle_cycles(4, 1'b1, 16);

        // Reset in the middle of a burst, then a fresh frame.
        reset_mid(1'b1, 16);
        do_frame(1'b1, 16, rand_smp(), '0, 1'b1, 16, 1'b1, -1, -1);

        // Random configurations, including clamped periods.
        cur_tl  = 1'b1;
        cur_per = 16;
        for (int f = 0; f < 12; f++) begin
            nx_tl  = 1'($urandom_range(0, 1));
            nx_per = int'($urandom_range(0, 40));
            do_frame(cur_tl, cur_per, rand_smp(), '0, nx_tl, nx_per, 1'b1,
                     int'($urandom_range(0, 8)), -1);
            cur_tl  = nx_tl;
            cur_per = nx_per;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ltc2387_rx_multi.md
Name: ltc2387_rx_multi

Overview:
- Parametrised receiver for LTC2387-family SAR ADCs. Generalises the 2-channel, fixed 18-bit, two-lane interface to N_CH channels, 16/18-bit resolution, and runtime-selectable one-lane or two-lane mode.
- Generates the conversion pulse and the gated data-clock burst every frame.
- Deserialises each channel and checks the returned DCO toggle pattern.
- Sits between the ADC pins (after IO buffers) and the DSP/DMA chain, all in the ADC clock domain.

Parameters:
- N_CH, 2, number of ADC channels sharing cnv/clkout.
- BITS, 18, sample resolution. Must be even and in 16..18.
- BURST_START, 2, frame cycle at which clkout_en first asserts.
- LATENCY, 1, cycles from clkout_en to the matching bit at din.
- PW, 8, width of the period input.

Ports:
- clk  in  1  ADC clock, rising-edge.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  run frames while high.
- two_lane  in  1  1 = two lanes (a,b) per channel, 0 = lane a only.
- period  in  PW  frame length in clk cycles.
- clr_err  in  1  clears sync_err (single-cycle pulse).
- din_a  in  N_CH  lane A serial data, one bit per channel.
- din_b  in  N_CH  lane B serial data.
- dco  in  N_CH  returned data clock, sampled as data.
- cnv  out  1  conversion start, one-cycle pulse.
- clkout_en  out  1  gate for the forwarded data clock.
- adc_data  out  N_CH*BITS  channel c at [c*BITS +: BITS], raw two's complement.
- adc_valid  out  1  one-cycle strobe; adc_data is updated in the same cycle.
- sync_err  out  N_CH  sticky DCO mismatch flag per channel.
- cfg_err  out  1  period below minimum, evaluated per frame.

Behaviour:
- Reset: one clk, resetn low → all outputs 0, state IDLE, counters 0. Applies even mid-burst; a partial sample is discarded.
- Config latch: two_lane and period are latched at frame start (cnt==0) only. Changes mid-frame take effect next frame.
- NCYC = two_lane ? BITS/2 : BITS.
- PMIN = BURST_START + NCYC + LATENCY + 1.
- Period clamp: if latched period < PMIN, use PMIN and set cfg_err for that frame. Otherwise cfg_err=0.
- States:
  - IDLE: enable=1 → CONV with cnt=0.
  - CONV: cnt 0..BURST_START-1. cnv=1 only at cnt==0.
  - BURST: clkout_en=1 for cnt BURST_START .. BURST_START+NCYC-1.
  - WAIT: remaining cycles until cnt==period-1.
    - enable=1 → CONV with cnt=0.
    - enable=0 → IDLE.
  - Deasserting enable mid-frame finishes the frame, including adc_valid.
- Capture qualifier: cap_en is clkout_en delayed LATENCY cycles through a shift register.
- On each cap_en cycle, per channel:
  - two-lane: sh <= {sh, din_a[c], din_b[c]}. A carries the MSB of each pair, so the first pair is D17,D16.
  - one-lane: sh <= {sh, din_a[c]}. MSB first.
- Output load: the cycle after the last cap_en, adc_data <= sh and adc_valid=1 for exactly one cycle. This is frame cycle BURST_START+NCYC+LATENCY.
- DCO check: capture index k (0-based) expects dco[c] == k[0].
  - Any mismatch sets sync_err[c].
  - Cleared by clr_err or reset.
  - A mismatch in the same cycle as clr_err wins: the flag stays set.
- adc_data holds its value between strobes. Never X after reset.

Decomposition:
- Package ltc2387_pkg:
  - state enum (IDLE, CONV, BURST, WAIT);
  - function ncyc(two_lane, BITS);
  - localparam for the PMIN formula.
- Sub-module ltc2387_deser, one per channel (generate loop). It holds the shift register, the DCO parity check and sync_err.
- Top-level FSM, counter and cap_en delay are shared across channels.

Test Plan:
1. Two-lane, BITS=18, period=16, BURST_START=2, LATENCY=1.
   - Stimulus: ch0 pairs 11,00,11,00,00,11,11,11,00; ch1 pairs 11,11,00,11,00,00,11,11,11; dco toggling correctly.
   - Required: adc_data ch0=0x330FC, ch1=0x3CC3F; adc_valid at frame cycle 12 each frame; cnv every 16 cycles; sync_err=0.
2. One-lane, BITS=18, period=24.
   - Stimulus: ch0 bits 0x2AAAA MSB first.
   - Required: clkout_en high 18 cycles (cnt 2..19); adc_valid at cnt 21; ch0=0x2AAAA.
3. Period clamp: two-lane, period=5 (PMIN=13).
   - Required: frame length 13 cycles; cfg_err=1; data still correct.
4. DCO fault: dco[1] stuck 0.
   - Required: sync_err=2'b10 after the first frame; sticky across frames; cleared on the clr_err pulse only once dco[1] is fixed.
5. Mode change mid-frame: two_lane 1→0 at cnt=5.
   - Required: current frame uses 9 cycles; next frame uses 18.
   - Also: enable dropped at cnt=3 → frame completes with adc_valid, then IDLE with cnv=0.
6. Reset mid-burst: resetn=0 at cnt=6 for 1 cycle.
   - Required: all outputs 0 next cycle; no adc_valid for the aborted frame.
   - Also: after resetn returns high, a fresh frame with cnv=1 starts if enable=1.
